// File: rtl/fifo_read.sv
// Word-to-byte serialiser: captures one NUM_BYTES-wide word and emits it LSB first
// over a valid/ready byte handshake, pulsing RD_fifo_done after the last byte.
module fifo_read #(
    parameter int unsigned NUM_BYTES = 8
) (
    input  logic                   clk_fifo_i,
    input  logic                   reset,
    input  logic                   load,
    input  logic [8*NUM_BYTES-1:0] data_in,
    input  logic                   byte_ready,
    output logic [7:0]             data_out,
    output logic                   byte_valid,
    output logic                   busy,
    output logic                   RD_fifo_done
);

    localparam int unsigned WORD_W = 8 * NUM_BYTES;
    localparam int unsigned PTR_W  = 4;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_BYTES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [PTR_W-1:0]  rdptr_q, rdptr_d;
    logic              xfer;

    // A byte moves only while SEND is registered and the transmitter is ready
    assign xfer = (state_q == SEND) && byte_ready;

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        rdptr_d = rdptr_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d = data_in;
                    rdptr_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (rdptr_q == LAST_PTR) begin
                        state_d = DONE;
                    end else begin
                        shreg_d = shreg_q >> 8;
                        rdptr_d = rdptr_q + PTR_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; flags follow the state being entered
    always_ff @(posedge clk_fifo_i) begin
        if (reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            rdptr_q      <= '0;
            byte_valid   <= 1'b0;
            busy         <= 1'b0;
            RD_fifo_done <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            rdptr_q      <= rdptr_d;
            byte_valid   <= (state_d == SEND);
            busy         <= (state_d != IDLE);
            RD_fifo_done <= (state_d == DONE);
        end
    end

    assign data_out = shreg_q[7:0];

endmodule
